// File: rtl/hub75_line_loader.sv
// -----------------------------------------------------------------------------
// hub75_line_loader
//
// Write-side feeder for the hub75 ping-pong line buffer. A valid/ready pixel
// stream carrying one row (bank-interleaved per column) is written into the
// half selected by the internal write pointer. The completed half is then
// offered to the scan/shift consumer through a line_rdy/line_ack swap
// handshake.
//
// Ports
//   i_clk, i_rst   clock, asynchronous active-high reset
//   i_in_data      pixel word
//   i_in_row       row tag, sampled with the first pixel of a row
//   i_in_last      marks the final word of a row
//   i_in_valid     stream valid
//   o_in_ready     stream ready (high while filling)
//   i_flush        synchronous abort of the row being filled
//   o_lb_wr_addr   {write half, column} to the line buffer
//   o_lb_wr_data   pixel word replicated into every bank word
//   o_lb_wr_mask   one-hot bank select
//   o_lb_wr_ena    write strobe
//   o_line_rdy     a filled half is waiting for the consumer
//   i_line_ack     consumer takes the filled half (swap)
//   o_rd_buf       half the consumer must read (address MSB)
//   o_rd_row       row tag of the half selected by o_rd_buf
//   o_err          sticky framing error
// -----------------------------------------------------------------------------
module hub75_line_loader #(
  parameter int N_BANKS    = 1,
  parameter int WORD_WIDTH = 24,
  parameter int LOG_N_COLS = 6,
  parameter int LOG_N_ROWS = 5
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic [WORD_WIDTH-1:0]         i_in_data,
  input  logic [LOG_N_ROWS-1:0]         i_in_row,
  input  logic                          i_in_last,
  input  logic                          i_in_valid,
  output logic                          o_in_ready,
  input  logic                          i_flush,
  output logic [LOG_N_COLS:0]           o_lb_wr_addr,
  output logic [N_BANKS*WORD_WIDTH-1:0] o_lb_wr_data,
  output logic [N_BANKS-1:0]            o_lb_wr_mask,
  output logic                          o_lb_wr_ena,
  output logic                          o_line_rdy,
  input  logic                          i_line_ack,
  output logic                          o_rd_buf,
  output logic [LOG_N_ROWS-1:0]         o_rd_row,
  output logic                          o_err
);

  localparam int N_COLS = 1 << LOG_N_COLS;
  localparam int BANK_W = (N_BANKS > 1) ? $clog2(N_BANKS) : 1;

  typedef enum logic {
    ST_FILL,
    ST_WAIT
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [LOG_N_COLS-1:0]   r_col;
  logic [BANK_W-1:0]       r_bank;
  logic                    r_wr_buf;
  logic [LOG_N_ROWS-1:0]   r_tag;

  logic                    w_xfer;
  logic                    w_pos_end;
  logic                    w_row_start;

  // A flushed transfer is swallowed: it neither writes nor moves the counters.
  assign w_xfer      = i_in_valid & o_in_ready & ~i_flush;
  assign w_pos_end   = (r_col == LOG_N_COLS'(N_COLS - 1)) &&
                       (r_bank == BANK_W'(N_BANKS - 1));
  assign w_row_start = (r_col == '0) && (r_bank == '0);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_FILL;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    o_in_ready  = 1'b0;
    o_line_rdy  = 1'b0;
    case (r_state)
      ST_FILL: begin
        o_in_ready = 1'b1;
        if (i_flush) begin
          w_state_nxt = ST_FILL;
        end else if (w_xfer && w_pos_end) begin
          w_state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        o_line_rdy = 1'b1;
        if (i_flush || i_line_ack) begin
          w_state_nxt = ST_FILL;
        end
      end
      default: begin
        w_state_nxt = ST_FILL;
      end
    endcase
  end

  // A stray in_last restarts the row at column 0; a full row always restarts.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_col  <= '0;
      r_bank <= '0;
    end else if (i_flush) begin
      r_col  <= '0;
      r_bank <= '0;
    end else if (w_xfer) begin
      if (w_pos_end || i_in_last) begin
        r_col  <= '0;
        r_bank <= '0;
      end else if (r_bank == BANK_W'(N_BANKS - 1)) begin
        r_bank <= '0;
        r_col  <= r_col + LOG_N_COLS'(1);
      end else begin
        r_bank <= r_bank + BANK_W'(1);
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_tag <= '0;
    end else if (w_xfer && w_row_start) begin
      r_tag <= i_in_row;
    end
  end

  // Framing error whenever in_last disagrees with the position end.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_err <= 1'b0;
    end else if (w_xfer && (i_in_last != w_pos_end)) begin
      o_err <= 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_buf <= 1'b0;
      o_rd_buf <= 1'b1;
      o_rd_row <= '0;
    end else if (!i_flush && (r_state == ST_WAIT) && i_line_ack) begin
      o_rd_buf <= r_wr_buf;
      r_wr_buf <= ~r_wr_buf;
      o_rd_row <= r_tag;
    end
  end

  // Address, data and mask hold between writes; only the strobe drops.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_lb_wr_ena  <= 1'b0;
      o_lb_wr_addr <= '0;
      o_lb_wr_data <= '0;
      o_lb_wr_mask <= '0;
    end else begin
      o_lb_wr_ena <= w_xfer;
      if (w_xfer) begin
        o_lb_wr_addr <= {r_wr_buf, r_col};
        o_lb_wr_data <= {N_BANKS{i_in_data}};
        o_lb_wr_mask <= N_BANKS'(1) << r_bank;
      end
    end
  end

endmodule

// File: tb/tb_hub75_line_loader.sv
// -----------------------------------------------------------------------------
// tb_hub75_line_loader
//
// Two instances: dutA (1 bank, 4 columns) for the single-bank walk-through and
// dutB (2 banks, 4 columns) for everything else. dutB is tracked by a
// behavioural model that counts words within a row as a linear position and
// derives column/bank with division.
// -----------------------------------------------------------------------------
module tb_hub75_line_loader;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // dutA: N_BANKS=1, LOG_N_COLS=2, WORD_WIDTH=8
  logic       aValid, aLast, aFlush, aAck;
  logic [7:0] aData;
  logic [4:0] aRow;
  logic       aReady, aLbEna, aLineRdy, aRdBuf, aErr;
  logic [2:0] aAddr;
  logic [7:0] aLbData;
  logic [0:0] aMask;
  logic [4:0] aRdRow;

  // dutB: N_BANKS=2, LOG_N_COLS=2, WORD_WIDTH=8
  logic        bValid, bLast, bFlush, bAck;
  logic [7:0]  bData;
  logic [4:0]  bRow;
  logic        bReady, bLbEna, bLineRdy, bRdBuf, bErr;
  logic [2:0]  bAddr;
  logic [15:0] bLbData;
  logic [1:0]  bMask;
  logic [4:0]  bRdRow;

  hub75_line_loader #(.N_BANKS(1), .WORD_WIDTH(8), .LOG_N_COLS(2), .LOG_N_ROWS(5)) dutA (
    .i_clk(clk), .i_rst(rst), .i_in_data(aData), .i_in_row(aRow), .i_in_last(aLast),
    .i_in_valid(aValid), .o_in_ready(aReady), .i_flush(aFlush), .o_lb_wr_addr(aAddr),
    .o_lb_wr_data(aLbData), .o_lb_wr_mask(aMask), .o_lb_wr_ena(aLbEna),
    .o_line_rdy(aLineRdy), .i_line_ack(aAck), .o_rd_buf(aRdBuf), .o_rd_row(aRdRow),
    .o_err(aErr)
  );

  hub75_line_loader #(.N_BANKS(2), .WORD_WIDTH(8), .LOG_N_COLS(2), .LOG_N_ROWS(5)) dutB (
    .i_clk(clk), .i_rst(rst), .i_in_data(bData), .i_in_row(bRow), .i_in_last(bLast),
    .i_in_valid(bValid), .o_in_ready(bReady), .i_flush(bFlush), .o_lb_wr_addr(bAddr),
    .o_lb_wr_data(bLbData), .o_lb_wr_mask(bMask), .o_lb_wr_ena(bLbEna),
    .o_line_rdy(bLineRdy), .i_line_ack(bAck), .o_rd_buf(bRdBuf), .o_rd_row(bRdRow),
    .o_err(bErr)
  );

  // Reference model for dutB: 8 words per row (4 columns x 2 banks).
  localparam int ROW_WORDS = 8;
  bit          mWait, mWrBuf, mRdBuf, mErr;
  int          mPos;
  logic [4:0]  mTag, mRdRow;
  bit          expEna;
  logic [2:0]  expAddr;
  logic [1:0]  expMask;
  logic [15:0] expData;

  task automatic resetModel();
    mWait = 0; mWrBuf = 0; mRdBuf = 1; mErr = 0; mPos = 0;
    mTag = '0; mRdRow = '0;
    expEna = 0; expAddr = '0; expMask = '0; expData = '0;
  endtask

  // Drive one cycle of dutB inputs (called at a negedge), advance the model,
  // and return at the following negedge.
  task automatic stepB(input logic v, input logic [7:0] d, input logic [4:0] r,
                       input logic l, input logic f, input logic a);
    bit oldWait, xfer, rowEnd;
    bValid = v; bData = d; bRow = r; bLast = l; bFlush = f; bAck = a;
    oldWait = mWait;
    xfer = v && !oldWait && !f;
    expEna = xfer;
    if (f) begin
      mPos = 0;
      mWait = 0;
    end else if (oldWait && a) begin
      mRdBuf = mWrBuf;
      mWrBuf = !mWrBuf;
      mRdRow = mTag;
      mWait = 0;
    end else if (xfer) begin
      expAddr = {mWrBuf, 2'(mPos / 2)};
      expMask = 2'(1 << (mPos % 2));
      expData = {d, d};
      if (mPos == 0) mTag = r;
      rowEnd = (mPos == ROW_WORDS - 1);
      if (l != rowEnd) mErr = 1;
      if (rowEnd) begin
        mPos = 0;
        mWait = 1;
      end else if (l) begin
        mPos = 0;
      end else begin
        mPos++;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    checks++; if (aReady !== 1'b1) begin errors++; $display("[TB] FAIL reset_a_ready: got %b expected 1", aReady); end
    checks++; if (aRdBuf !== 1'b1) begin errors++; $display("[TB] FAIL reset_a_rd_buf: got %b expected 1", aRdBuf); end
    checks++; if (bReady !== 1'b1) begin errors++; $display("[TB] FAIL reset_b_ready: got %b expected 1", bReady); end
    checks++; if (bRdBuf !== 1'b1) begin errors++; $display("[TB] FAIL reset_b_rd_buf: got %b expected 1", bRdBuf); end
    checks++; if ({bLbEna, bAddr, bMask, bLbData} !== '0) begin errors++; $display("[TB] FAIL reset_b_lb: got ena=%b addr=%h mask=%h data=%h expected all 0", bLbEna, bAddr, bMask, bLbData); end
    checks++; if ({bLineRdy, bErr, bRdRow} !== '0) begin errors++; $display("[TB] FAIL reset_b_misc: got rdy=%b err=%b row=%h expected 0", bLineRdy, bErr, bRdRow); end
  endtask

  task automatic test_single_bank();
    for (int i = 0; i < 4; i++) begin
      aValid = 1'b1; aData = 8'hA0 + 8'(i); aLast = (i == 3);
      @(posedge clk); @(negedge clk);
      checks++; if (aLbEna !== 1'b1) begin errors++; $display("[TB] FAIL sb_ena[%0d]: got %b expected 1", i, aLbEna); end
      checks++; if (aAddr !== 3'(i)) begin errors++; $display("[TB] FAIL sb_addr[%0d]: got %h expected %h", i, aAddr, 3'(i)); end
      checks++; if (aLbData !== 8'hA0 + 8'(i)) begin errors++; $display("[TB] FAIL sb_data[%0d]: got %h expected %h", i, aLbData, 8'hA0 + 8'(i)); end
      checks++; if (aMask !== 1'b1) begin errors++; $display("[TB] FAIL sb_mask[%0d]: got %b expected 1", i, aMask); end
      checks++; if (aLineRdy !== (i == 3)) begin errors++; $display("[TB] FAIL sb_line_rdy[%0d]: got %b expected %b", i, aLineRdy, (i == 3)); end
    end
    aValid = 1'b0; aLast = 1'b0; aAck = 1'b1;
    @(posedge clk); @(negedge clk);
    checks++; if (aRdBuf !== 1'b0) begin errors++; $display("[TB] FAIL sb_ack_rd_buf: got %b expected 0", aRdBuf); end
    checks++; if (aLineRdy !== 1'b0 || aLbEna !== 1'b0) begin errors++; $display("[TB] FAIL sb_ack_state: got rdy=%b ena=%b expected 0 0", aLineRdy, aLbEna); end
    aAck = 1'b0; aValid = 1'b1; aData = 8'h55;
    @(posedge clk); @(negedge clk);
    checks++; if (aAddr !== 3'b100 || aLbEna !== 1'b1) begin errors++; $display("[TB] FAIL sb_next_half: got addr=%h ena=%b expected 4 1", aAddr, aLbEna); end
    aValid = 1'b0;
    @(posedge clk); @(negedge clk);
    checks++; if (aLbEna !== 1'b0 || aAddr !== 3'b100) begin errors++; $display("[TB] FAIL sb_hold: got ena=%b addr=%h expected 0 4", aLbEna, aAddr); end
  endtask

  task automatic test_two_bank();
    logic [2:0] tAddr [4] = '{3'd0, 3'd0, 3'd1, 3'd1};
    logic [1:0] tMask [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
    for (int i = 0; i < 4; i++) begin
      stepB(1'b1, 8'(i + 1), 5'd7, 1'b0, 1'b0, 1'b0);
      checks++; if (bLbEna !== 1'b1 || bAddr !== tAddr[i] || bMask !== tMask[i]) begin errors++; $display("[TB] FAIL tb_write[%0d]: got ena=%b addr=%h mask=%b expected 1 %h %b", i, bLbEna, bAddr, bMask, tAddr[i], tMask[i]); end
      checks++; if (bLbData !== {8'(i + 1), 8'(i + 1)}) begin errors++; $display("[TB] FAIL tb_data[%0d]: got %h expected %h", i, bLbData, {8'(i + 1), 8'(i + 1)}); end
    end
    for (int i = 4; i < 8; i++) stepB(1'b1, 8'(i + 1), 5'd0, (i == 7), 1'b0, 1'b0);
    checks++; if (bLineRdy !== 1'b1 || bReady !== 1'b0) begin errors++; $display("[TB] FAIL tb_row_done: got rdy=%b ready=%b expected 1 0", bLineRdy, bReady); end
    checks++; if (bErr !== 1'b0) begin errors++; $display("[TB] FAIL tb_no_err: got %b expected 0", bErr); end
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < 10; i++) begin
      stepB(1'b1, 8'($urandom), 5'($urandom), 1'b0, 1'b0, 1'b0);
      checks++; if (bReady !== 1'b0 || bLbEna !== 1'b0 || bLineRdy !== 1'b1) begin errors++; $display("[TB] FAIL bp_hold[%0d]: got ready=%b ena=%b rdy=%b expected 0 0 1", i, bReady, bLbEna, bLineRdy); end
    end
    stepB(1'b0, 8'h00, 5'd0, 1'b0, 1'b0, 1'b1);
    checks++; if (bRdBuf !== 1'b0 || bRdRow !== 5'd7 || bLineRdy !== 1'b0) begin errors++; $display("[TB] FAIL bp_ack: got rd_buf=%b rd_row=%0d rdy=%b expected 0 7 0", bRdBuf, bRdRow, bLineRdy); end
    stepB(1'b1, 8'h33, 5'd9, 1'b0, 1'b0, 1'b0);
    checks++; if (bAddr !== 3'b100 || bMask !== 2'b01 || bLbEna !== 1'b1) begin errors++; $display("[TB] FAIL bp_next_row: got addr=%h mask=%b ena=%b expected 4 01 1", bAddr, bMask, bLbEna); end
    for (int i = 1; i < 8; i++) stepB(1'b1, 8'h33 + 8'(i), 5'd0, (i == 7), 1'b0, 1'b0);
    stepB(1'b0, 8'h00, 5'd0, 1'b0, 1'b0, 1'b1);
    checks++; if (bRdBuf !== 1'b1 || bRdRow !== 5'd9) begin errors++; $display("[TB] FAIL bp_second_ack: got rd_buf=%b rd_row=%0d expected 1 9", bRdBuf, bRdRow); end
  endtask

  task automatic test_last_error();
    stepB(1'b1, 8'h40, 5'd3, 1'b0, 1'b0, 1'b0);
    stepB(1'b1, 8'h41, 5'd3, 1'b1, 1'b0, 1'b0);
    checks++; if (bErr !== 1'b1 || bLineRdy !== 1'b0) begin errors++; $display("[TB] FAIL le_err: got err=%b rdy=%b expected 1 0", bErr, bLineRdy); end
    stepB(1'b1, 8'h42, 5'd4, 1'b0, 1'b0, 1'b0);
    checks++; if (bAddr !== 3'b000 || bMask !== 2'b01) begin errors++; $display("[TB] FAIL le_restart: got addr=%h mask=%b expected 0 01", bAddr, bMask); end
    for (int i = 1; i < 8; i++) stepB(1'b1, 8'h42 + 8'(i), 5'd0, (i == 7), 1'b0, 1'b0);
    checks++; if (bLineRdy !== 1'b1 || bErr !== 1'b1) begin errors++; $display("[TB] FAIL le_clean_row: got rdy=%b err=%b expected 1 1", bLineRdy, bErr); end
    stepB(1'b0, 8'h00, 5'd0, 1'b0, 1'b0, 1'b1);
    checks++; if (bRdRow !== 5'd4 || bRdBuf !== 1'b0) begin errors++; $display("[TB] FAIL le_ack: got rd_row=%0d rd_buf=%b expected 4 0", bRdRow, bRdBuf); end
  endtask

  task automatic test_flush();
    stepB(1'b1, 8'h50, 5'd10, 1'b0, 1'b0, 1'b0);
    stepB(1'b1, 8'h51, 5'd10, 1'b0, 1'b0, 1'b0);
    stepB(1'b1, 8'h52, 5'd10, 1'b0, 1'b1, 1'b0);
    checks++; if (bLbEna !== 1'b0) begin errors++; $display("[TB] FAIL fl_no_write: got ena=%b expected 0", bLbEna); end
    stepB(1'b1, 8'h60, 5'd11, 1'b0, 1'b0, 1'b0);
    checks++; if (bAddr !== 3'b100 || bMask !== 2'b01) begin errors++; $display("[TB] FAIL fl_restart: got addr=%h mask=%b expected 4 01", bAddr, bMask); end
    for (int i = 1; i < 8; i++) stepB(1'b1, 8'h60 + 8'(i), 5'd0, (i == 7), 1'b0, 1'b0);
    stepB(1'b0, 8'h00, 5'd0, 1'b0, 1'b1, 1'b1);
    checks++; if (bLineRdy !== 1'b0 || bReady !== 1'b1) begin errors++; $display("[TB] FAIL fl_drop_row: got rdy=%b ready=%b expected 0 1", bLineRdy, bReady); end
    checks++; if (bRdBuf !== 1'b0 || bRdRow !== 5'd4) begin errors++; $display("[TB] FAIL fl_no_swap: got rd_buf=%b rd_row=%0d expected 0 4", bRdBuf, bRdRow); end
    stepB(1'b1, 8'h70, 5'd12, 1'b0, 1'b0, 1'b0);
    checks++; if (bAddr !== 3'b100 || bLbEna !== 1'b1) begin errors++; $display("[TB] FAIL fl_same_half: got addr=%h ena=%b expected 4 1", bAddr, bLbEna); end
  endtask

  task automatic test_random();
    logic v, l, f, a;
    for (int n = 0; n < 400; n++) begin
      v = ($urandom % 4) != 0;
      l = (mPos == ROW_WORDS - 1) ? (($urandom % 8) != 0) : (($urandom % 20) == 0);
      f = ($urandom % 40) == 0;
      a = ($urandom % 3) == 0;
      stepB(v, 8'($urandom), 5'($urandom), l, f, a);
      checks++; if (bReady !== logic'(!mWait) || bLineRdy !== logic'(mWait)) begin errors++; $display("[TB] FAIL rnd_handshake[%0d]: got ready=%b rdy=%b expected %b %b", n, bReady, bLineRdy, !mWait, mWait); end
      checks++; if (bLbEna !== logic'(expEna) || bAddr !== expAddr || bMask !== expMask || bLbData !== expData) begin errors++; $display("[TB] FAIL rnd_write[%0d]: got ena=%b addr=%h mask=%b data=%h expected %b %h %b %h", n, bLbEna, bAddr, bMask, bLbData, expEna, expAddr, expMask, expData); end
      checks++; if (bRdBuf !== logic'(mRdBuf) || bRdRow !== mRdRow || bErr !== logic'(mErr)) begin errors++; $display("[TB] FAIL rnd_status[%0d]: got rd_buf=%b rd_row=%h err=%b expected %b %h %b", n, bRdBuf, bRdRow, bErr, mRdBuf, mRdRow, mErr); end
    end
  endtask

  task automatic test_async_reset();
    stepB(1'b0, 8'h00, 5'd0, 1'b0, 1'b1, 1'b0);
    stepB(1'b1, 8'h80, 5'd5, 1'b0, 1'b0, 1'b0);
    stepB(1'b1, 8'h81, 5'd5, 1'b0, 1'b0, 1'b0);
    #2 rst = 1'b1;
    #1;
    checks++; if (bReady !== 1'b1 || bRdBuf !== 1'b1) begin errors++; $display("[TB] FAIL ar_state: got ready=%b rd_buf=%b expected 1 1", bReady, bRdBuf); end
    checks++; if ({bLbEna, bAddr, bMask, bLbData} !== '0) begin errors++; $display("[TB] FAIL ar_lb: got ena=%b addr=%h mask=%b data=%h expected all 0", bLbEna, bAddr, bMask, bLbData); end
    checks++; if ({bErr, bLineRdy, bRdRow} !== '0) begin errors++; $display("[TB] FAIL ar_misc: got err=%b rdy=%b row=%h expected 0", bErr, bLineRdy, bRdRow); end
    checks++; if (aReady !== 1'b1 || aRdBuf !== 1'b1 || aLbEna !== 1'b0) begin errors++; $display("[TB] FAIL ar_dut_a: got ready=%b rd_buf=%b ena=%b expected 1 1 0", aReady, aRdBuf, aLbEna); end
    @(negedge clk);
    rst = 1'b0;
    resetModel();
    stepB(1'b1, 8'h90, 5'd6, 1'b0, 1'b0, 1'b0);
    checks++; if (bAddr !== 3'b000 || bLbEna !== 1'b1 || bMask !== 2'b01) begin errors++; $display("[TB] FAIL ar_restart: got addr=%h ena=%b mask=%b expected 0 1 01", bAddr, bLbEna, bMask); end
    stepB(1'b0, 8'h00, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    aValid = 0; aLast = 0; aFlush = 0; aAck = 0; aData = '0; aRow = '0;
    bValid = 0; bLast = 0; bFlush = 0; bAck = 0; bData = '0; bRow = '0;
    resetModel();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    test_reset();
    test_single_bank();
    test_two_bank();
    test_backpressure();
    test_last_error();
    test_flush();
    test_random();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
